// File: rtl/incident_pkg.sv
// ---------------------------------------------------------------------------
// incident_pkg : shared types and constants for the incident record path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package incident_pkg;

  localparam logic [7:0] INC_HDR   = 8'hE0;
  localparam int         FRAME_LEN = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
  } record_t;

  function automatic logic [7:0] record_csum(input record_t r);
    logic [7:0] sum;
    sum = r.b0 + r.b1 + r.b2 + r.b3;
    return sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/incident_fifo.sv
// ---------------------------------------------------------------------------
// incident_fifo : synchronous show-ahead FIFO of 32-bit incident records
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module incident_fifo
  import incident_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  record_t                       wr_data,
  input  logic                          rd_en,
  output record_t                       rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  record_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_ok, rd_ok;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    rd_ok    = rd_en && !empty;
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);
    count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/incident_reporter.sv
// ---------------------------------------------------------------------------
// incident_reporter : queues incident records, streams b0..b3 + checksum frames
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module incident_reporter
  import incident_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              incident_inform,
  input  logic [7:0]        incident_b0,
  input  logic [7:0]        incident_b1,
  input  logic [7:0]        incident_b2,
  input  logic [7:0]        incident_b3,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                     state_q, state_d;
  logic [2:0]                 idx_q, idx_d;
  logic [FRAME_LEN-1:0][7:0]  frame_q, frame_d;
  logic                       overflow_q, overflow_d;
  logic [DROP_W-1:0]          drop_cnt_q, drop_cnt_d;
  logic                       busy_q, busy_d;

  record_t                    wr_rec, rd_rec;
  logic [CNT_W-1:0]           fifo_count, count_next;
  logic                       fifo_full, fifo_empty;
  logic                       pop, accept, drop, handshake;

  assign wr_rec    = {incident_b0, incident_b1, incident_b2, incident_b3};
  assign tx_valid  = (state_q == SEND);
  assign tx_data   = tx_valid ? frame_q[idx_q] : 8'h00;
  assign handshake = tx_valid && tx_ready;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  incident_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (wr_rec),
    .rd_en   (pop),
    .rd_data (rd_rec),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencer: the last byte's handshake reloads directly from the FIFO.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: pop = !fifo_empty;
      SEND: begin
        if (handshake) begin
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = SEND;
      idx_d   = '0;
      frame_d = {record_csum(rd_rec), rd_rec.b3, rd_rec.b2, rd_rec.b1, rd_rec.b0};
    end
  end

  always_comb begin
    accept     = incident_inform && (!fifo_full || pop);
    drop       = incident_inform && !accept;
    count_next = fifo_count + CNT_W'(accept) - CNT_W'(pop);
    overflow_d = drop;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;
    busy_d     = (state_d != IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_incident_reporter.sv
// ---------------------------------------------------------------------------
// tb_incident_reporter : scoreboard bench for incident_reporter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_incident_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic       inform;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_cnt;

  incident_reporter #(
    .FIFO_DEPTH (4),
    .DROP_W     (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .incident_inform (inform),
    .incident_b0     (b0),
    .incident_b1     (b1),
    .incident_b2     (b2),
    .incident_b3     (b3),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .overflow        (overflow),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] exp_q[$];
  int         cyc         = 0;
  int         hs_total    = 0;
  int         gap_seen    = 0;
  int         ovf_cycles  = 0;
  int         prev_hs_cyc = 0;
  bit         have_prev   = 0;
  bit         prev_stall  = 0;
  logic [7:0] prev_data   = 8'h00;

  // Output monitor: pops the scoreboard on every accepted byte
  always @(negedge clk) begin
    cyc++;
    if (overflow) ovf_cycles++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", tx_valid, 1);
        check_val("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        hs_total++;
        if (have_prev && (cyc - prev_hs_cyc > 1)) gap_seen++;
        have_prev   = 1;
        prev_hs_cyc = cyc;
        check_val("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_val("tx_byte", tx_data, exp_q.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input bit expect_ok);
    logic [7:0] cs;
    b0 = a; b1 = b; b2 = c; b3 = d;
    inform = 1'b1;
    if (expect_ok) begin
      cs = a + b + c + d;
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
      exp_q.push_back(cs);
    end
    tick();
    inform = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int hs0;
    int ovf0;
    rst = 1'b1; inform = 1'b0; tx_ready = 1'b0;
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check_val("rst_valid", tx_valid, 0);
    check_val("rst_data", tx_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // single record, free-running sink
    tx_ready = 1'b1; gap_seen = 0; have_prev = 0;
    send(8'hE0, 8'h14, 8'h21, 8'h80, 1);
    @(negedge clk);
    check_val("lat_valid0", tx_valid, 0);
    check_val("lat_busy", busy, 1);
    @(negedge clk);
    check_val("lat_valid1", tx_valid, 1);
    check_val("lat_b0", tx_data, 8'hE0);
    wait_drain(20, "t1_drain");
    repeat (2) tick();
    @(negedge clk);
    check_val("t1_idle_valid", tx_valid, 0);
    check_val("t1_idle_busy", busy, 0);
    check_val("t1_gap", gap_seen, 0);

    // backpressure pattern 1,0,0
    tick();
    tx_ready = 1'b0;
    send(8'hE0, 8'h14, 8'h21, 8'h80, 1);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      tx_ready = (i % 3 == 0);
      tick();
    end
    check_val("t2_drain", exp_q.size(), 0);
    tx_ready = 1'b0;
    repeat (3) tick();

    // burst of 6 into a stalled sink: one drop
    ovf0 = ovf_cycles;
    for (int i = 0; i < 6; i++)
      send(8'hE0, 8'(i), 8'(8'h10 + i), 8'(8'h40 + 3 * i), i < 5);
    repeat (2) tick();
    check_val("t3_ovf_pulses", ovf_cycles - ovf0, 1);
    check_val("t3_drop", drop_cnt, 1);
    check_val("t3_busy", busy, 1);
    hs0 = hs_total; gap_seen = 0; have_prev = 0;
    tx_ready = 1'b1;
    wait_drain(40, "t3_drain");
    check_val("t3_bytes", hs_total - hs0, 25);
    check_val("t3_gap", gap_seen, 0);
    repeat (3) tick();

    // inform lands on the checksum handshake with the FIFO full
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(8'hE0, 8'(8'hA0 + i), 8'(8'h33 * i), 8'hC3, 1);
    tick();
    ovf0 = ovf_cycles;
    tx_ready = 1'b1;
    repeat (4) tick();
    send(8'hE0, 8'h5A, 8'hA5, 8'hFF, 1);
    wait_drain(60, "t4_drain");
    tick();
    check_val("t4_no_ovf", ovf_cycles - ovf0, 0);
    check_val("t4_drop", drop_cnt, 1);
    repeat (3) tick();

    // reset mid-frame with two records queued
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(8'hE0, 8'(8'h01 + i), 8'h02, 8'h03, 1);
    tx_ready = 1'b1;
    repeat (3) tick();
    tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    @(negedge clk);
    check_val("t5_valid", tx_valid, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    hs0 = hs_total;
    tx_ready = 1'b1;
    repeat (10) tick();
    check_val("t5_no_bytes", hs_total - hs0, 0);
    @(negedge clk);
    check_val("t5_idle_valid", tx_valid, 0);
    check_val("t5_idle_busy", busy, 0);
    tick();

    // drop counter saturation
    tx_ready = 1'b0;
    ovf0 = ovf_cycles;
    for (int i = 0; i < 300; i++)
      send(8'hE0, 8'(i), 8'(i * 7), 8'h11, i < 5);
    repeat (2) tick();
    check_val("t6_drop_sat", drop_cnt, 8'hFF);
    check_val("t6_ovf_cycles", ovf_cycles - ovf0, 295);
    tx_ready = 1'b1;
    wait_drain(60, "t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
